// File: rtl/frame_aligner_param_if.sv
// -----------------------------------------------------------------------------
// frame_aligner_param_if
// Bundles the receive stream and the alignment status of frame_aligner_param.
//
// Handshake: rx_valid qualifies rx_data. There is no ready; the aligner accepts
// every word presented with rx_valid = 1 on a rising clock edge, and words with
// rx_valid = 0 are ignored entirely. Status outputs are registered and change
// only on the edge that accepts a word (sync_lost also clears on idle edges).
//
// Signals:
//   rx_valid          master -> slave  word qualifier
//   rx_data           master -> slave  stream word, DATA_W bits
//   fr_byte_position  slave -> master  position of last accepted word in frame
//   frame_detect      slave -> master  high while locked
//   hdr_id            slave -> master  header of last good frame (0 = A, 1 = B)
//   sync_lost         slave -> master  one-cycle pulse when lock is dropped
//   fsm_state         slave -> master  debug view of the aligner state
// -----------------------------------------------------------------------------
interface frame_aligner_param_if #(
    parameter int DATA_W = 8,
    parameter int POS_W  = 4
);
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic [POS_W-1:0]  fr_byte_position;
    logic              frame_detect;
    logic              hdr_id;
    logic              sync_lost;
    logic [1:0]        fsm_state;

    modport master (
        output rx_valid, rx_data,
        input  fr_byte_position, frame_detect, hdr_id, sync_lost, fsm_state
    );

    modport slave (
        input  rx_valid, rx_data,
        output fr_byte_position, frame_detect, hdr_id, sync_lost, fsm_state
    );
endinterface

// File: rtl/frame_aligner_param.sv
// -----------------------------------------------------------------------------
// frame_aligner_param
// Finds fixed-length frames in a word stream by their 2-word header (pattern A
// or B), locks after LOCK_CNT consecutive good headers and drops lock after
// UNLOCK_CNT consecutive bad headers. Reports word position within the frame.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    frame_aligner_param_if.slave (rx_valid/rx_data in, status out)
//
// fsm_state encoding: 0 = HUNT, 1 = PRESYNC, 2 = SYNC.
// -----------------------------------------------------------------------------
module frame_aligner_param #(
    parameter int                  DATA_W     = 8,
    parameter int                  FRAME_LEN  = 12,
    parameter int                  POS_W      = $clog2(FRAME_LEN),
    parameter logic [2*DATA_W-1:0] HDR_A      = 16'hAFAA,
    parameter logic [2*DATA_W-1:0] HDR_B      = 16'hBA55,
    parameter int                  LOCK_CNT   = 3,
    parameter int                  UNLOCK_CNT = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    frame_aligner_param_if.slave       bus
);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(UNLOCK_CNT + 1);

    localparam logic [POS_W-1:0]  POS_LAST = POS_W'(FRAME_LEN - 1);
    localparam logic [POS_W-1:0]  POS_ONE  = POS_W'(1);
    localparam logic [GOOD_W-1:0] GOOD_MAX = GOOD_W'(LOCK_CNT);
    localparam logic [GOOD_W-1:0] GOOD_ONE = GOOD_W'(1);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   prev_word;
    logic [POS_W-1:0]    pos;
    logic [GOOD_W-1:0]   good_cnt;
    logic [MISS_W-1:0]   miss_cnt;
    logic                frame_detect_q;
    logic                hdr_id_q;
    logic                sync_lost_q;

    logic [2*DATA_W-1:0] pair;
    logic                is_a;
    logic                is_b;
    logic                hdr_match;
    logic [POS_W-1:0]    pos_next;
    logic                at_check;
    logic [GOOD_W-1:0]   good_inc;
    logic [MISS_W-1:0]   miss_inc;

    always_comb begin
        pair      = {prev_word, bus.rx_data};
        is_a      = (pair == HDR_A);
        is_b      = (pair == HDR_B);
        hdr_match = is_a | is_b;
        pos_next  = (pos == POS_LAST) ? '0 : pos + 1'b1;
        // The word being accepted lands on position 1: it is header word1.
        at_check  = (pos_next == POS_ONE);
        good_inc  = (good_cnt == GOOD_MAX) ? good_cnt : good_cnt + 1'b1;
        miss_inc  = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= HUNT;
            prev_word      <= '0;
            pos            <= '0;
            good_cnt       <= '0;
            miss_cnt       <= '0;
            frame_detect_q <= 1'b0;
            hdr_id_q       <= 1'b0;
            sync_lost_q    <= 1'b0;
        end else begin
            sync_lost_q <= 1'b0;
            if (bus.rx_valid) begin
                prev_word <= bus.rx_data;
                case (state)
                    HUNT: begin
                        pos <= '0;
                        if (hdr_match) begin
                            pos      <= POS_ONE;
                            good_cnt <= GOOD_ONE;
                            hdr_id_q <= is_b;
                            if (LOCK_CNT == 1) begin
                                state          <= SYNC;
                                frame_detect_q <= 1'b1;
                            end else begin
                                state <= PRESYNC;
                            end
                        end
                    end
                    PRESYNC: begin
                        pos <= pos_next;
                        if (at_check) begin
                            if (hdr_match) begin
                                good_cnt <= good_inc;
                                hdr_id_q <= is_b;
                                if (good_inc == GOOD_MAX) begin
                                    state          <= SYNC;
                                    frame_detect_q <= 1'b1;
                                end
                            end else begin
                                // This word stays in prev_word, so HUNT tests
                                // the very next word against it.
                                state    <= HUNT;
                                good_cnt <= '0;
                                pos      <= '0;
                            end
                        end
                    end
                    SYNC: begin
                        pos <= pos_next;
                        if (at_check) begin
                            if (hdr_match) begin
                                miss_cnt <= '0;
                                hdr_id_q <= is_b;
                            end else if (miss_inc == MISS_MAX) begin
                                state          <= HUNT;
                                good_cnt       <= '0;
                                miss_cnt       <= '0;
                                pos            <= '0;
                                frame_detect_q <= 1'b0;
                                sync_lost_q    <= 1'b1;
                            end else begin
                                miss_cnt <= miss_inc;
                            end
                        end
                    end
                    default: begin
                        state <= HUNT;
                        pos   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.fr_byte_position = pos;
    assign bus.frame_detect     = frame_detect_q;
    assign bus.hdr_id           = hdr_id_q;
    assign bus.sync_lost        = sync_lost_q;
    assign bus.fsm_state        = state;
endmodule

// File: doc/frame_aligner_param.md
# frame_aligner_param

Parametrised frame aligner for a byte/word stream carrying fixed-length frames that start with one of two 2-word header patterns. It generalises the fixed 12-byte, 8-bit aligner: data width, frame length and both header patterns are parameters. It adds a data-valid qualifier, programmable lock and loss-of-lock thresholds, header identification, and a sync-loss pulse. It sits directly behind the receive deserializer and feeds word position and alignment status to downstream frame parsers.

## Interface
- DATA_W, 8, width of one stream word
- FRAME_LEN, 12, words per frame including the 2 header words; legal range 3..256
- POS_W, $clog2(FRAME_LEN), width of position output
- HDR_A, 16'hAFAA, header pattern A {word0, word1}, width 2*DATA_W
- HDR_B, 16'hBA55, header pattern B {word0, word1}, width 2*DATA_W
- LOCK_CNT, 3, consecutive good headers needed to declare lock; must be >= 1
- UNLOCK_CNT, 4, consecutive bad headers needed to drop lock; must be >= 1

- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- rx_valid  in  1  rx_data qualifier; only valid words advance the block
- rx_data  in  DATA_W  stream word
- fr_byte_position  out  POS_W  position of the last accepted word in the frame; 0 is header word0
- frame_detect  out  1  high while in SYNC
- hdr_id  out  1  header of the last good frame: 0 = A, 1 = B
- sync_lost  out  1  one-cycle pulse on the SYNC -> HUNT transition

## Operation
- prev_word register: loaded with rx_data on every valid word, in every state.
- Header match: the pair {prev_word, rx_data} equals HDR_A or HDR_B. The pair is evaluated only on a valid word.
- States:
  - HUNT: on every valid word, test for a header match. On a match, set pos = 1, good_cnt = 1 and hdr_id, then go to PRESYNC. If LOCK_CNT == 1, go to SYNC directly.
  - PRESYNC: pos advances on each valid word and wraps FRAME_LEN-1 -> 0. The header is checked only at pos 1.
    - Match: good_cnt++ and update hdr_id. When good_cnt reaches LOCK_CNT, go to SYNC.
    - Mismatch: go to HUNT, good_cnt = 0. The next valid word is tested immediately.
  - SYNC: same position tracking, with the check at pos 1.
    - Match: miss_cnt = 0 and update hdr_id.
    - Mismatch: miss_cnt++. When it reaches UNLOCK_CNT, go to HUNT, clear both counters and pulse sync_lost.
    - Position keeps free-running through misses.
- Header-like words inside the payload are ignored in PRESYNC and SYNC.
- A mix of A and B headers across frames counts as consecutive good frames.
- rx_valid = 0: no register changes; all outputs hold, except that sync_lost is 0.
- Counter widths: $clog2(LOCK_CNT+1) and $clog2(UNLOCK_CNT+1). Counters saturate and never wrap.

## Timing
- Reset values: fr_byte_position = 0, frame_detect = 0, hdr_id = 0, sync_lost = 0, state HUNT, prev_word = 0, counters 0.
- Reset mid-frame or while in SYNC: all outputs take their reset values on the next edge.
- All outputs are registered. A word accepted at edge N is reflected at edge N (visible in cycle N+1).
- fr_byte_position is 0 in HUNT. It reads 1 in the cycle after the edge that accepts the matching header word1.
- frame_detect rises in the cycle after the edge that accepts word1 of the LOCK_CNT-th consecutive good header.
- frame_detect falls, and sync_lost is high for exactly that one cycle, after the edge that accepts word1 of the UNLOCK_CNT-th consecutive bad header.
- Latency is counted in valid words; invalid cycles stretch it.
- Position wrap: FRAME_LEN-1 -> 0 with no gap cycle.

## Test plan
- Reset held 3 cycles with random rx_data, rx_valid = 1 -> all outputs 0, no lock.
- Three back-to-back frames: AF AA followed by 10 bytes each -> fr_byte_position runs 1,2..11,0,1. frame_detect rises the cycle after the 3rd AA byte; hdr_id = 0.
- Frames with headers BA55, AFAA, BA55 -> lock at the same point as above; hdr_id = 1 after lock. A payload byte pair AF AA at positions 5/6 causes no effect.
- Two good frames, then header AF 00 -> back to HUNT, frame_detect stays 0, position 0. Three further good frames -> lock.
- Locked, then 3 bad headers followed by 1 good -> frame_detect stays 1. Then 4 bad headers -> frame_detect falls with a 1-cycle sync_lost pulse after the 4th bad word1.
- Locked stream with rx_valid = 0 for 2 cycles inside the payload and inside the header pair -> outputs hold and lock is kept. Reset asserted mid-SYNC -> all outputs 0 next cycle.
